// File: rtl/inst_fetch_queue.sv
// Sequential instruction fetcher with an in-order response queue
// and a drain phase that discards responses made stale by a redirect.
module inst_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      DRAIN
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] out_q, out_d;
   logic [CW-1:0] disc_q, disc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;

   logic [31:0]   qdata [DEPTH];
   logic [31:0]   qpc   [DEPTH];

   logic          req_fire;
   logic          rsp_fire;
   logic          redir;
   logic          push;
   logic          pop;
   logic          wr;
   logic [CW:0]   occ;
   logic [CW-1:0] inc;
   logic [CW-1:0] dec;
   logic [31:0]   rsp_pc;

   assign occ      = {1'b0, cnt_q} + {1'b0, out_q};
   assign redir    = redirect && (state_q != BOOT);
   assign req_fire = mem_req_valid && mem_req_ready;
   assign rsp_fire = mem_rsp_valid && (out_q != '0);
   assign push     = rsp_fire && (state_q == RUN);
   assign pop      = inst_valid && inst_ready;
   assign wr       = push && !redir;
   assign inc      = {{(CW-1){1'b0}}, req_fire};
   assign dec      = {{(CW-1){1'b0}}, rsp_fire};

   // In RUN the outstanding requests are the words just below fetch_pc
   assign rsp_pc = fetch_pc_q - {{(30-CW){1'b0}}, out_q, 2'b00};

   assign mem_req_valid = (state_q == RUN) && (occ < LIMIT);
   assign mem_addr      = fetch_pc_q;
   assign inst_valid    = (cnt_q != '0);
   assign inst_data     = inst_valid ? qdata[head_q] : 32'h0;
   assign inst_pc       = inst_valid ? qpc[head_q] : 32'h0;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      out_d      = out_q + inc - dec;
      disc_d     = disc_q;
      cnt_d      = cnt_q;
      head_d     = head_q;
      tail_d     = tail_q;

      if (req_fire)
         fetch_pc_d = fetch_pc_q + 32'd4;

      unique case (1'b1)
         push && pop: begin
            head_d = head_q + 1'b1;
            tail_d = tail_q + 1'b1;
         end
         push && !pop: begin
            tail_d = tail_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
         end
         pop && !push: begin
            head_d = head_q + 1'b1;
            cnt_d  = cnt_q - 1'b1;
         end
         default: ;
      endcase

      unique case (state_q)
         BOOT: state_d = RUN;
         RUN: ;
         DRAIN: begin
            if (rsp_fire) begin
               disc_d = disc_q - 1'b1;
               if (disc_d == '0)
                  state_d = RUN;
            end
         end
         default: state_d = BOOT;
      endcase

      // Redirect wins over every same-cycle queue or fetch update
      if (redir) begin
         cnt_d      = '0;
         head_d     = '0;
         tail_d     = '0;
         fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
         disc_d     = out_d;
         state_d    = (out_d != '0) ? DRAIN : RUN;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= BOOT;
         fetch_pc_q <= RESET_PC;
         out_q      <= '0;
         disc_q     <= '0;
         cnt_q      <= '0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         out_q      <= out_d;
         disc_q     <= disc_d;
         cnt_q      <= cnt_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) begin
         qdata[tail_q] <= mem_rsp_data;
         qpc[tail_q]   <= rsp_pc;
      end
   end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameters SHALL be:
- DEPTH, default 4: queue entries, power of two, 2..16.
- RESET_PC, default 32'h0000_0000: first fetch address, word-aligned.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock, all state on rising edge.
- reset, in, 1: asynchronous, active-high.
- redirect, in, 1: branch/jump taken, discard queue.
- redirect_pc, in, 32: new fetch address.
- mem_req_valid, out, 1: fetch request.
- mem_req_ready, in, 1: memory accepts request.
- mem_addr, out, 32: request word address.
- mem_rsp_valid, in, 1: instruction returned, in request order.
- mem_rsp_data, in, 32: instruction word.
- inst_valid, out, 1: queue head valid.
- inst_ready, in, 1: decode consumes head.
- inst_data, out, 32: head instruction.
- inst_pc, out, 32: head address.

REQ-003 Reset SHALL be asynchronous and active-high on port reset; clk SHALL be the only clock.

Function
REQ-004 The block SHALL hold three states: BOOT, RUN and DRAIN; BOOT SHALL last exactly one cycle after reset deasserts, then go to RUN.

REQ-005 A request SHALL transfer when mem_req_valid and mem_req_ready are both high at a rising edge; fetch_pc SHALL then advance by 4, with modulo 2^32 wrap (32'hFFFF_FFFC goes to 0).

REQ-006 mem_req_valid SHALL be high only in RUN, and only when (queue occupancy + outstanding requests) < DEPTH; mem_addr SHALL equal fetch_pc.

REQ-007 The outstanding count SHALL increment on a request transfer and decrement on mem_rsp_valid; both in one cycle SHALL leave it unchanged.

REQ-008 In RUN, mem_rsp_valid SHALL push {mem_rsp_data, pc of the oldest outstanding request} into the queue.

REQ-009 inst_valid SHALL equal queue not empty; inst_data and inst_pc SHALL present the head entry; the head SHALL pop when inst_valid and inst_ready are both high.

REQ-010 A push and pop in the same cycle SHALL both occur, occupancy unchanged, including when the queue is full.

REQ-011 Latency: a response received at edge N SHALL appear on inst_valid/inst_data after edge N when the queue was empty; there is no combinational path from mem_rsp to inst_*.

REQ-012 On redirect in any state other than BOOT, at that edge:
- the queue SHALL empty;
- fetch_pc SHALL load {redirect_pc[31:2], 2'b00};
- discard_cnt SHALL load the outstanding count after that cycle's request/response updates;
- the state SHALL go to DRAIN if that value is nonzero, otherwise RUN.

REQ-013 In DRAIN:
- no requests SHALL issue;
- each mem_rsp_valid SHALL be dropped and SHALL decrement discard_cnt;
- at zero the state SHALL return to RUN.

REQ-014 Redirect SHALL override a simultaneous pop, push or request transfer. A request accepted in the redirect cycle SHALL be counted for discard; a response in the redirect cycle SHALL be dropped.

REQ-015 Redirect asserted during DRAIN SHALL restart per REQ-012 with the current outstanding count.

REQ-016 mem_rsp_valid with zero outstanding SHALL be ignored and SHALL not change any state.

REQ-017 Redirect during BOOT SHALL be ignored.

Reset
REQ-018 While reset is high, the following SHALL hold: state=BOOT, fetch_pc=RESET_PC, queue empty, outstanding=0, discard_cnt=0, inst_valid=0, mem_req_valid=0, inst_data=0, inst_pc=0.

REQ-019 Reset asserted mid-transaction SHALL abandon all in-flight requests without waiting for responses.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset release, mem_req_ready=1, one-cycle memory, inst_ready=1 -> mem_addr 0,4,8,12 on consecutive cycles; inst_pc follows one cycle after each response.
- inst_ready=0, DEPTH=4 -> exactly 4 requests issue, then mem_req_valid=0; inst_pc=0 held; raise inst_ready -> one pop per cycle and requests resume.
- 3 requests outstanding, redirect to 32'h0000_0103 -> next request address 32'h0000_0100 only after 3 responses are dropped; inst_valid=0 during DRAIN.
- Redirect coincident with mem_rsp_valid and inst_ready -> that response is not queued; inst_valid=0 next cycle.
- fetch_pc=32'hFFFF_FFFC accepted -> next mem_addr=32'h0000_0000.
- Reset asserted during DRAIN -> all outputs at REQ-018 values immediately; mem_addr=RESET_PC after BOOT.
